// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file writeback path.
//   XLEN / REG_ADDR_W : writeback word width and register address width
//   REG_X0            : hardwired-zero register address (writes to it are dropped)
//   wb_entry_t        : one buffered writeback {rd, data}
//   req_id_t          : requester identity (ALU = 0, load unit = 1)
package regfile_ctrl_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries, one per requester.
//   clk, rst      : clock, async active-high reset
//   push, push_ent: enqueue (caller qualifies with !full)
//   pop           : dequeue head (caller qualifies with !empty)
//   head          : current head entry (valid when !empty)
//   full, empty   : occupancy flags, derived from registered state only
//   ent_vld, ents : per-slot valid bits and storage, for the busy scoreboard
module wb_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_ent,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      ent_vld,
  output wb_entry_t [DEPTH-1:0] ents
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Push and pop never touch the same slot: push needs !full, pop needs !empty,
    // and with both true the write slot differs from the head slot.
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign ent_vld = vld_q;
  assign ents    = mem_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (REQ0) and the
// load unit (REQ1). Each requester is buffered in a wb_fifo; the two heads are
// round-robin arbitrated and the winner is popped into one output register that
// drives the register-file write controls. BUSY_MASK flags every destination
// register with a write still buffered or sitting in the output register.
// Ports:
//   CK_REF, RST                  : clock, async active-high reset
//   REQn_VALID/RD/DATA, REQn_READY : requester handshakes (READY = FIFO not full)
//   REG_RD_WRN, RD_REG_OFFSET, REG_DATA_IN : register-file write controls (0 = write)
//   BUSY_MASK                    : in-flight destination scoreboard, bit 0 always 0
// Optional feature macro WB_BYPASS_EN adds the RS1/RS2 forwarding ports, which
// return the write-port data when it targets the requested source register.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  CK_REF,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic [REG_ADDR_W-1:0] REQ0_RD,
  input  logic [XLEN-1:0]       REQ0_DATA,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [REG_ADDR_W-1:0] REQ1_RD,
  input  logic [XLEN-1:0]       REQ1_DATA,
  output logic                  REQ1_READY,
  output logic                  REG_RD_WRN,
  output logic [REG_ADDR_W-1:0] RD_REG_OFFSET,
  output logic [XLEN-1:0]       REG_DATA_IN,
  output logic [31:0]           BUSY_MASK
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] RS1_REG_OFFSET,
  input  logic [REG_ADDR_W-1:0] RS2_REG_OFFSET,
  input  logic [XLEN-1:0]       RS1_RF_DATA,
  input  logic [XLEN-1:0]       RS2_RF_DATA,
  output logic [XLEN-1:0]       RS1_FWD_DATA,
  output logic [XLEN-1:0]       RS2_FWD_DATA
`endif
);
  logic [1:0]                       req_vld, push, pop, full, empty;
  wb_entry_t [1:0]                  req_ent, head;
  logic [1:0][FIFO_DEPTH-1:0]       ent_vld;
  wb_entry_t [1:0][FIFO_DEPTH-1:0]  ents;

  assign req_vld = {REQ1_VALID, REQ0_VALID};
  assign req_ent = {{REQ1_RD, REQ1_DATA}, {REQ0_RD, REQ0_DATA}};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    assign push[g] = req_vld[g] & ~full[g];
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (CK_REF),
      .rst      (RST),
      .push     (push[g]),
      .push_ent (req_ent[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .ent_vld  (ent_vld[g]),
      .ents     (ents[g])
    );
  end

  assign REQ0_READY = ~full[0];
  assign REQ1_READY = ~full[1];

  // Round-robin arbiter and output register.
  req_id_t               last_q, last_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] off_q, off_d;
  logic [XLEN-1:0]       data_q, data_d;
  wb_entry_t             win;

  always_comb begin
    pop     = 2'b00;
    last_d  = last_q;
    wr_en_d = 1'b0;
    off_d   = off_q;
    data_d  = data_q;
    win     = head[0];
    // On a tie, the requester that did not win last time goes first.
    if (!empty[0] && (empty[1] || last_q == REQ_LOAD)) begin
      pop[0] = 1'b1;
      last_d = REQ_ALU;
      win    = head[0];
    end else if (!empty[1]) begin
      pop[1] = 1'b1;
      last_d = REQ_LOAD;
      win    = head[1];
    end
    if (pop != 2'b00) begin
      // x0 consumes the slot and updates offset/data, but never strobes a write.
      wr_en_d = (win.rd != REG_X0);
      off_d   = win.rd;
      data_d  = win.data;
    end
  end

  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      last_q  <= REQ_LOAD;
      wr_en_q <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      last_q  <= last_d;
      wr_en_q <= wr_en_d;
      off_q   <= off_d;
      data_q  <= data_d;
    end
  end

  assign REG_RD_WRN    = ~wr_en_q;
  assign RD_REG_OFFSET = off_q;
  assign REG_DATA_IN   = data_q;

  // Scoreboard: built only from registered state, so no input-to-output path.
  always_comb begin
    BUSY_MASK = '0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (ent_vld[r][i]) BUSY_MASK[ents[r][i].rd] = 1'b1;
    if (wr_en_q) BUSY_MASK[off_q] = 1'b1;
    BUSY_MASK[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign RS1_FWD_DATA = (wr_en_q && RS1_REG_OFFSET != REG_X0 && RS1_REG_OFFSET == off_q)
                        ? data_q : RS1_RF_DATA;
  assign RS2_FWD_DATA = (wr_en_q && RS2_REG_OFFSET != REG_X0 && RS2_REG_OFFSET == off_q)
                        ? data_q : RS2_RF_DATA;
`endif
endmodule
